// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [3:0] DIG_OFF = 4'b1111;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low digit selects, indexed by digit number (digit 0 is rightmost).
  localparam logic [3:0][3:0] DIG_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Active-low hex font {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [15:0][6:0] FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern {g..a}.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver with per-slot dead time.
// Define SEG7_LZ_SUPPRESS_EN to blank leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned DIGIT_HZ  = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  output logic [3:0]  o_dig,
  output logic [7:0]  o_seg,
  output logic        o_frame
);

  localparam int unsigned SLOT      = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CNT_W     = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam int unsigned SHOW_LAST = SLOT - BLANK_CYC - 1;
  localparam int unsigned SLOT_LAST = SLOT - 1;

  generate
    if (BLANK_CYC < 1 || BLANK_CYC >= SLOT) begin : g_bad_blank
      $error("seg7_scan_driver: BLANK_CYC must satisfy 1 <= BLANK_CYC < CLK_HZ/DIGIT_HZ");
    end
  endgenerate

  state_t             state, nxt_state;
  logic [1:0]         idx, nxt_idx;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [15:0]        shadow_value, nxt_value;
  logic [3:0]         shadow_dp, nxt_dp;
  logic [3:0]         nxt_dig;
  logic [7:0]         nxt_seg;
  logic               nxt_frame;
  logic [3:0]         nibble;
  logic [6:0]         font_c;
  logic               lz_blank;

  // Slot sequencing; the shadow latch fires only when digit 0 begins a frame.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    nxt_value = shadow_value;
    nxt_dp    = shadow_dp;
    nxt_frame = 1'b0;
    if (!i_en) begin
      nxt_state = IDLE;
      nxt_idx   = 2'd0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = SHOW;
          nxt_idx   = 2'd0;
          nxt_cnt   = '0;
          nxt_frame = 1'b1;
        end
        SHOW: begin
          nxt_cnt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(SHOW_LAST)) nxt_state = BLANK;
        end
        BLANK: begin
          if (cnt == CNT_W'(SLOT_LAST)) begin
            nxt_state = SHOW;
            nxt_cnt   = '0;
            nxt_idx   = idx + 2'd1;
            nxt_frame = (idx == 2'd3);
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_idx   = 2'd0;
          nxt_cnt   = '0;
        end
      endcase
      if (nxt_frame) begin
        nxt_value = i_value;
        nxt_dp    = i_dp;
      end
    end
  end

  assign nibble = nxt_value[{nxt_idx, 2'b00} +: 4];

`ifdef SEG7_LZ_SUPPRESS_EN
  assign lz_blank = (nxt_idx != 2'd0) && ((nxt_value >> {nxt_idx, 2'b00}) == 16'h0000);
`else
  assign lz_blank = 1'b0;
`endif

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg_c  (font_c)
  );

  // Outputs follow the next state so digit select and segments switch together.
  always_comb begin
    nxt_dig = DIG_OFF;
    nxt_seg = SEG_OFF;
    if (nxt_state == SHOW) begin
      nxt_dig = DIG_SEL[nxt_idx];
      nxt_seg = {~nxt_dp[nxt_idx], (lz_blank ? 7'h7F : font_c)};
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      idx          <= 2'd0;
      cnt          <= '0;
      shadow_value <= 16'h0000;
      shadow_dp    <= 4'h0;
      o_dig        <= DIG_OFF;
      o_seg        <= SEG_OFF;
      o_frame      <= 1'b0;
    end else begin
      state        <= nxt_state;
      idx          <= nxt_idx;
      cnt          <= nxt_cnt;
      shadow_value <= nxt_value;
      shadow_dp    <= nxt_dp;
      o_dig        <= nxt_dig;
      o_seg        <= nxt_seg;
      o_frame      <= nxt_frame;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SLOT=10, BLANK_CYC=2).
module tb_seg7_scan_driver;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned DIGIT_HZ  = 100;
  localparam int unsigned BLANK_CYC = 2;
  localparam int SLOT     = 10;
  localparam int SHOW_LEN = 8;
  localparam int FRAME    = 40;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic [3:0]  o_dig;
  logic [7:0]  o_seg;
  logic        o_frame;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_HZ    (CLK_HZ),
    .DIGIT_HZ  (DIGIT_HZ),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_value (i_value),
    .i_dp    (i_dp),
    .o_dig   (o_dig),
    .o_seg   (o_seg),
    .o_frame (o_frame)
  );

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
    logic       frame;
  } obs_t;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][7:0] exp_seg;
  } vec_t;

  localparam logic [7:0] FONT_TB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [3:0] DIG_EXP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  obs_t        exp_q[$];
  obs_t        last_obs;
  int          checks = 0;
  int          errors = 0;
  bit          m_on;
  int          m_run;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  vec_t        vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [15:0] v, input logic [3:0] dp, input int k);
    logic [15:0] hi;
    logic [7:0]  s;
    hi = v >> (4 * k);
    s  = FONT_TB[hi[3:0]];
`ifdef SEG7_LZ_SUPPRESS_EN
    if (k != 0 && hi == 16'h0000) s = 8'hFF;
`endif
    if (dp[k]) s[7] = 1'b0;
    return s;
  endfunction

  // Time-based model: position within a 40-cycle frame since the display came on.
  task automatic model_update(output obs_t e);
    int pos, d;
    e = '{dig: 4'hF, seg: 8'hFF, frame: 1'b0};
    if (!i_rst_n || !i_en) begin
      m_on  = 1'b0;
      m_run = 0;
      return;
    end
    if (!m_on) begin
      m_on  = 1'b1;
      m_run = 0;
    end else begin
      m_run++;
    end
    pos = m_run % FRAME;
    d   = pos / SLOT;
    if (pos == 0) begin
      m_val   = i_value;
      m_dp    = i_dp;
      e.frame = 1'b1;
    end
    if ((pos % SLOT) < SHOW_LEN) begin
      e.dig = DIG_EXP[d];
      e.seg = seg_of(m_val, m_dp, d);
    end
  endtask

  task automatic step();
    obs_t e, g;
    @(posedge clk);
    model_update(e);
    exp_q.push_back(e);
    @(negedge clk);
    g = '{dig: o_dig, seg: o_seg, frame: o_frame};
    last_obs = g;
    e = exp_q.pop_front();
    check("cycle", 32'(g), 32'(e));
  endtask

  task automatic wait_frame();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (last_obs.frame) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout @%0t: got no o_frame in 60 cycles, expected one", $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected $finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int nfr;
    i_rst_n = 1'b0;
    i_en    = 1'b0;
    i_value = 16'h1234;
    i_dp    = 4'h0;
    m_on    = 1'b0;
    m_run   = 0;
    m_val   = 16'h0;
    m_dp    = 4'h0;

    vecs[0] = '{16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{16'h8888, 4'b0100, {8'h80, 8'h00, 8'h80, 8'h80}};
    vecs[2] = '{16'hABCD, 4'b0000, {8'h88, 8'h83, 8'hC6, 8'hA1}};
`ifdef SEG7_LZ_SUPPRESS_EN
    vecs[3] = '{16'h0042, 4'b0000, {8'hFF, 8'hFF, 8'h99, 8'hA4}};
    vecs[4] = '{16'h0000, 4'b1000, {8'h7F, 8'hFF, 8'hFF, 8'hC0}};
`else
    vecs[3] = '{16'h0042, 4'b0000, {8'hC0, 8'hC0, 8'h99, 8'hA4}};
    vecs[4] = '{16'h0000, 4'b1000, {8'h40, 8'hC0, 8'hC0, 8'hC0}};
`endif

    // Reset state
    step();
    step();
    check("reset_dig", 32'(o_dig), 32'(4'b1111));
    check("reset_seg", 32'(o_seg), 32'(8'hFF));
    check("reset_frame", 32'(o_frame), 32'(1'b0));
    i_rst_n = 1'b1;

    // Disabled display stays dark
    nfr = 0;
    repeat (100) begin
      step();
      nfr += int'(last_obs.frame);
    end
    check("idle_frames", 32'(nfr), 32'(0));

    // Enable: first digit one cycle later, frame every 40 cycles
    i_en = 1'b1;
    nfr  = 0;
    step();
    nfr += int'(last_obs.frame);
    check("first_frame", 32'(o_frame), 32'(1'b1));
    check("first_dig", 32'(o_dig), 32'(4'b1110));
    check("first_seg", 32'(o_seg), 32'(8'h99));
    repeat (79) begin
      step();
      nfr += int'(last_obs.frame);
    end
    check("frame_count", 32'(nfr), 32'(2));

    // Value change while digit 2 shows must not tear the current frame
    repeat (22) step();
    i_value = 16'hABCD;
    repeat (3) step();
    check("tear_d2_dig", 32'(o_dig), 32'(4'b1011));
    check("tear_d2_seg", 32'(o_seg), 32'(8'hA4));
    repeat (10) step();
    check("tear_d3_seg", 32'(o_seg), 32'(8'hF9));
    repeat (6) step();
    check("tear_next_frame", 32'(o_frame), 32'(1'b1));
    check("tear_next_d0", 32'(o_seg), 32'(8'hA1));

    // Enable dropped mid digit 1, raised 5 cycles later
    repeat (12) step();
    check("pre_drop_dig", 32'(o_dig), 32'(4'b1101));
    i_en = 1'b0;
    step();
    check("drop_dig", 32'(o_dig), 32'(4'b1111));
    check("drop_seg", 32'(o_seg), 32'(8'hFF));
    repeat (4) step();
    i_en = 1'b1;
    step();
    check("reen_frame", 32'(o_frame), 32'(1'b1));
    check("reen_dig", 32'(o_dig), 32'(4'b1110));
    check("reen_seg", 32'(o_seg), 32'(8'hA1));

    // Table-driven decode: each row shown for one full frame
    for (int r = 0; r < 5; r++) begin
      i_value = vecs[r].value;
      i_dp    = vecs[r].dp;
      wait_frame();
      for (int k = 0; k < 4; k++) begin
        if (k > 0) repeat (SLOT) step();
        check($sformatf("row%0d_dig%0d", r, k), 32'(o_dig), 32'(DIG_EXP[k]));
        check($sformatf("row%0d_seg%0d", r, k), 32'(o_seg), 32'(vecs[r].exp_seg[k]));
      end
    end

    // Asynchronous reset in the middle of a visible slot
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_dig", 32'(o_dig), 32'(4'b1111));
    check("async_rst_seg", 32'(o_seg), 32'(8'hFF));
    check("async_rst_frame", 32'(o_frame), 32'(1'b0));
    repeat (3) step();
    i_rst_n = 1'b1;
    i_value = 16'h1234;
    i_dp    = 4'h0;
    step();
    check("post_rst_frame", 32'(o_frame), 32'(1'b1));
    check("post_rst_seg", 32'(o_seg), 32'(8'h99));
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
